miriscv_mem_arbiter: RTL and testbench

Shares one memory port between the instruction fetch path and the load/store unit of the miriscv core. Each cycle, a fixed-priority arbiter with an anti-starvation counter picks a requester. Up to MAX_OUTST accepted transactions are tracked in an in-order owner FIFO, and every memory response is routed back to the requester that issued it. Instruction responses outstanding at a fetch redirect (flush) are discarded, so the fetch path never sees stale instructions.

---
 rtl/miriscv_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU of the miriscv core.
// Fixed priority with an anti-starvation limit; an in-order owner FIFO routes each response back to its issuer.
module miriscv_mem_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MAX_OUTST      = 2,
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic                clk_i,
    input  logic                arstn_i,

    input  logic                instr_req_i,
    input  logic [XLEN-1:0]     instr_addr_i,
    input  logic                instr_flush_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [XLEN-1:0]     instr_rdata_o,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned STV_W = $clog2(DATA_BURST_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(DATA_BURST_MAX);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

    logic [CNT_W-1:0]     outst_cnt_q, outst_cnt_d;
    logic [STV_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [MAX_OUTST-1:0] owner_q, owner_d;  // 1 = data, 0 = instr
    logic [MAX_OUTST-1:0] drop_q, drop_d;

    logic issue_ok;
    logic sel_data;
    logic sel_instr;
    logic accept;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        issue_ok    = (outst_cnt_q < CNT_MAX);
        sel_data    = data_req_i && (!instr_req_i || (starve_cnt_q < STV_MAX));
        sel_instr   = instr_req_i && !sel_data;
        mem_req_o   = arstn_i && issue_ok && (data_req_i || instr_req_i);
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Address/control are gated by the reset pin so the port stays quiet while arstn_i is low.
        if (arstn_i && sel_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (arstn_i && sel_instr) begin
            mem_be_o    = '1;
            mem_addr_o  = instr_addr_i;
        end

        accept      = mem_req_o && mem_gnt_i;
        data_gnt_o  = accept && sel_data;
        instr_gnt_o = accept && sel_instr;

        // A response with nothing outstanding belongs to no one and is ignored.
        pop            = arstn_i && mem_rvalid_i && (outst_cnt_q != '0);
        data_rvalid_o  = pop && owner_q[rd_ptr_q];
        instr_rvalid_o = pop && !owner_q[rd_ptr_q] && !drop_q[rd_ptr_q];
        data_rdata_o   = mem_rdata_i;
        instr_rdata_o  = mem_rdata_i;
    end

    always_comb begin
        owner_d      = owner_q;
        drop_d       = drop_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        outst_cnt_d  = outst_cnt_q;
        starve_cnt_d = starve_cnt_q;

        // Flush before push: a fetch accepted alongside the flush is a new-path fetch and must survive.
        if (instr_flush_i) begin
            drop_d = drop_q | ~owner_q;
        end
        if (accept) begin
            owner_d[wr_ptr_q] = sel_data;
            drop_d[wr_ptr_q]  = 1'b0;
        end

        case ({accept, pop})
            2'b10:   outst_cnt_d = outst_cnt_q + CNT_W'(1);
            2'b01:   outst_cnt_d = outst_cnt_q - CNT_W'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase

        if (!instr_req_i || instr_gnt_o) begin
            starve_cnt_d = '0;
        end else if (data_gnt_o && (starve_cnt_q < STV_MAX)) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            outst_cnt_q  <= '0;
            starve_cnt_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            // NOTE: the owner FIFO is only a few flops, so it is reset too; validity still comes from outst_cnt_q.
            owner_q      <= '0;
            drop_q       <= '0;
        end else begin
            outst_cnt_q  <= outst_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench for miriscv_mem_arbiter: directed stimulus pushes expected responses,
// a separate monitor pops and compares whenever the DUT raises an rvalid.
module tb_miriscv_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            arstn_i;
    logic            instr_req_i;
    logic [XLEN-1:0] instr_addr_i;
    logic            instr_flush_i;
    logic            instr_gnt_o;
    logic            instr_rvalid_o;
    logic [XLEN-1:0] instr_rdata_o;
    logic            data_req_i;
    logic            data_we_i;
    logic [3:0]      data_be_i;
    logic [XLEN-1:0] data_addr_i;
    logic [XLEN-1:0] data_wdata_i;
    logic            data_gnt_o;
    logic            data_rvalid_o;
    logic [XLEN-1:0] data_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    miriscv_mem_arbiter #(
        .XLEN           (XLEN),
        .MAX_OUTST      (2),
        .DATA_BURST_MAX (4)
    ) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_flush_i  (instr_flush_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            is_data;
        logic [XLEN-1:0] rdata;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] pend_data[$];
    int              pend_due[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              lat   = 1;
    logic            hold_resp = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Memory model: records accepted requests, answers in order after `lat` cycles unless held.
    // The returned word is {addr[15:0], 16'hBEEF}; the stimulus below spells those words out by hand.
    task automatic step();
        if (mem_req_o && mem_gnt_i) begin
            pend_data.push_back({mem_addr_o[15:0], 16'hBEEF});
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        if (!hold_resp && (pend_data.size() > 0) && (pend_due[0] <= cyc)) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend_data.pop_front();
            pend_due.delete(0);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0BAD_0BAD;
        end
    endtask

    task automatic cycle_req(input string tag,
                             input logic ireq, input logic [XLEN-1:0] iaddr,
                             input logic dreq, input logic dwe, input logic [3:0] dbe,
                             input logic [XLEN-1:0] daddr, input logic [XLEN-1:0] dwdata,
                             input logic flush, input logic exp_ig, input logic exp_dg,
                             input logic exp_rsp, input logic [XLEN-1:0] exp_rdata);
        exp_t e;
        instr_req_i   = ireq;
        instr_addr_i  = iaddr;
        instr_flush_i = flush;
        data_req_i    = dreq;
        data_we_i     = dwe;
        data_be_i     = dbe;
        data_addr_i   = daddr;
        data_wdata_i  = dwdata;
        #1;
        check({tag, " mem_req"}, mem_req_o, exp_ig | exp_dg);
        check({tag, " instr_gnt"}, instr_gnt_o, exp_ig);
        check({tag, " data_gnt"}, data_gnt_o, exp_dg);
        if (exp_dg) begin
            check({tag, " mem_we"}, mem_we_o, dwe);
            check({tag, " mem_be"}, mem_be_o, dbe);
            check({tag, " mem_addr"}, mem_addr_o, daddr);
            check({tag, " mem_wdata"}, mem_wdata_o, dwdata);
        end else if (exp_ig) begin
            check({tag, " mem_we"}, mem_we_o, 1'b0);
            check({tag, " mem_be"}, mem_be_o, 4'hF);
            check({tag, " mem_addr"}, mem_addr_o, iaddr);
            check({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
        end
        if (exp_rsp) begin
            e.is_data = exp_dg;
            e.rdata   = exp_rdata;
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic idle(input string tag);
        cycle_req(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_instr(input string tag, input logic [XLEN-1:0] addr, input logic flush,
                            input logic gnt, input logic rsp, input logic [XLEN-1:0] rdata);
        cycle_req(tag, 1, addr, 0, 0, 0, 0, 0, flush, gnt, 0, rsp, rdata);
    endtask

    task automatic do_data(input string tag, input logic we, input logic [3:0] be, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wdata, input logic gnt, input logic [XLEN-1:0] rdata);
        cycle_req(tag, 0, 0, 1, we, be, addr, wdata, 0, 0, gnt, gnt, rdata);
    endtask

    // Monitor: every rvalid must match the head of the scoreboard in owner and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (instr_rvalid_o || data_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected rvalid: instr_rvalid=%b data_rvalid=%b, expected none",
                             instr_rvalid_o, data_rvalid_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp data_rvalid", data_rvalid_o, e.is_data);
                    check("rsp instr_rvalid", instr_rvalid_o, !e.is_data);
                    check("rsp rdata", e.is_data ? data_rdata_o : instr_rdata_o, e.rdata);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_quiet(input string tag);
        check({tag, " mem_req"}, mem_req_o, 1'b0);
        check({tag, " instr_gnt"}, instr_gnt_o, 1'b0);
        check({tag, " data_gnt"}, data_gnt_o, 1'b0);
        check({tag, " instr_rvalid"}, instr_rvalid_o, 1'b0);
        check({tag, " data_rvalid"}, data_rvalid_o, 1'b0);
        check({tag, " mem_we"}, mem_we_o, 1'b0);
        check({tag, " mem_be"}, mem_be_o, 4'h0);
        check({tag, " mem_addr"}, mem_addr_o, 32'h0);
        check({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        logic [9:0] inst_win;
        logic       gi;

        arstn_i = 1'b0;  instr_req_i = 1'b0; instr_addr_i = '0; instr_flush_i = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Reset: requesters and memory all active, the port must stay silent.
        repeat (2) @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h44; data_req_i = 1'b1; data_we_i = 1'b1;
        data_be_i = 4'hF; data_addr_i = 32'h48; data_wdata_i = 32'hFFFF; mem_rvalid_i = 1'b1;
        #1;
        check_quiet("reset");
        @(negedge clk_i);
        instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; mem_rvalid_i = 1'b0;
        arstn_i = 1'b1;

        // Fetch-only stream, 1-cycle memory: a grant every cycle.
        do_instr("fetch 0x0", 32'h0, 0, 1, 1, 32'h0000_BEEF);
        do_instr("fetch 0x4", 32'h4, 0, 1, 1, 32'h0004_BEEF);
        do_instr("fetch 0x8", 32'h8, 0, 1, 1, 32'h0008_BEEF);
        idle("fetch drain0");
        idle("fetch drain1");

        // Memory stalls: request visible, no grant.
        mem_gnt_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'hA0; data_we_i = 1'b0; data_be_i = 4'hF;
        #1;
        check("stall mem_req", mem_req_o, 1'b1);
        check("stall data_gnt", data_gnt_o, 1'b0);
        check("stall mem_addr", mem_addr_o, 32'hA0);
        step();
        mem_gnt_i = 1'b1;
        do_data("stall retry", 0, 4'hF, 32'hA0, 0, 1, 32'h00A0_BEEF);
        idle("stall drain");

        // Starvation limit: D,D,D,D,I,D,D,D,D,I.
        inst_win = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            gi = inst_win[i];
            cycle_req($sformatf("starve%0d", i), 1, 32'h200, 1, 0, 4'hF, 32'h300, 0, 0,
                      gi, !gi, 1, gi ? 32'h0200_BEEF : 32'h0300_BEEF);
        end
        idle("starve drain0");
        idle("starve drain1");

        // Mixed ordering with 2-cycle memory.
        lat = 2;
        do_instr("mix instr", 32'h20, 0, 1, 1, 32'h0020_BEEF);
        do_data("mix write", 1, 4'b0011, 32'h80, 32'h1234_5678, 1, 32'h0080_BEEF);
        idle("mix drain0");
        idle("mix drain1");
        idle("mix drain2");
        lat = 1;

        // Backpressure: two outstanding, third waits until the cycle after the first response.
        hold_resp = 1'b1;
        do_data("bp 0x90", 0, 4'hF, 32'h90, 0, 1, 32'h0090_BEEF);
        do_data("bp 0x94", 0, 4'hF, 32'h94, 0, 1, 32'h0094_BEEF);
        do_data("bp full0", 0, 4'hF, 32'h98, 0, 0, 0);
        hold_resp = 1'b0;
        do_data("bp full1", 0, 4'hF, 32'h98, 0, 0, 0);
        do_data("bp pop", 0, 4'hF, 32'h98, 0, 0, 0);
        do_data("bp issue", 0, 4'hF, 32'h98, 0, 1, 32'h0098_BEEF);
        idle("bp drain0");
        idle("bp drain1");
        idle("bp drain2");

        // Spurious response with the FIFO empty.
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_DEAD;
        #1;
        check("spurious instr_rvalid", instr_rvalid_o, 1'b0);
        check("spurious data_rvalid", data_rvalid_o, 1'b0);
        idle("spurious cycle");

        // Flush with a new fetch accepted in the flush cycle.
        hold_resp = 1'b1;
        do_instr("fl 0x10", 32'h10, 0, 1, 0, 0);
        do_instr("fl 0x100", 32'h100, 1, 1, 1, 32'h0100_BEEF);
        hold_resp = 1'b0;
        idle("fl drain0");
        idle("fl drain1");
        idle("fl drain2");
        idle("fl drain3");

        // Flush in the same cycle the entry pops: it is still delivered.
        hold_resp = 1'b1;
        do_instr("pf 0x14", 32'h14, 0, 1, 1, 32'h0014_BEEF);
        hold_resp = 1'b0;
        idle("pf wait");
        cycle_req("pf flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle("pf drain");

        // Two resident fetches flushed: both swallowed, then normal fetch.
        hold_resp = 1'b1;
        do_instr("ds 0x18", 32'h18, 0, 1, 0, 0);
        do_instr("ds 0x1C", 32'h1C, 0, 1, 0, 0);
        hold_resp = 1'b0;
        cycle_req("ds flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle("ds drain0");
        idle("ds drain1");
        idle("ds drain2");
        do_instr("ds after", 32'h24, 0, 1, 1, 32'h0024_BEEF);
        idle("ds after drain");

        // Asynchronous reset with two transactions outstanding.
        hold_resp = 1'b1;
        do_instr("rst 0x50", 32'h50, 0, 1, 0, 0);
        cycle_req("rst 0x54", 0, 0, 1, 1, 4'hF, 32'h54, 32'hCAFE, 0, 0, 1, 0, 0);
        instr_req_i = 1'b1; instr_addr_i = 32'h58; data_req_i = 1'b1; data_addr_i = 32'h5C;
        #3;
        arstn_i      = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        check_quiet("mid reset");
        @(negedge clk_i);
        @(negedge clk_i);
        check("held reset mem_req", mem_req_o, 1'b0);
        check("held reset instr_gnt", instr_gnt_o, 1'b0);
        instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; mem_rvalid_i = 1'b0;
        arstn_i   = 1'b1;
        hold_resp = 1'b0;
        idle("post rst0");
        #1;
        check("late rvalid instr_rvalid", instr_rvalid_o, 1'b0);
        check("late rvalid data_rvalid", data_rvalid_o, 1'b0);
        idle("post rst1");
        idle("post rst2");
        do_instr("post rst new", 32'h60, 0, 1, 1, 32'h0060_BEEF);
        idle("post rst drain0");
        idle("post rst drain1");

        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
